// File: rtl/agc_multi_seq.sv
// Measurement sequencer for a bank of agc_core instances: runs an integration
// period, waits for the accumulators to settle, then snapshots every channel.
module agc_multi_seq #(
  parameter int NCHAN         = 8,
  parameter int SQ_W          = 25,
  parameter int CMP_W         = 21,
  parameter int TIMER_W       = 18,
  parameter int CAPTURE_DELAY = 6,
  localparam int RD_W         = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     auto_i,
  input  logic [TIMER_W-1:0]       period_i,
  input  logic [NCHAN*SQ_W-1:0]    sq_accum_i,
  input  logic [NCHAN*CMP_W-1:0]   gt_accum_i,
  input  logic [NCHAN*CMP_W-1:0]   lt_accum_i,
  output logic                     agc_tick_o,
  output logic                     agc_ce_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     capture_o,
  output logic                     aborted_o,
  output logic                     cfg_err_o,
  output logic [7:0]               seq_o,
  input  logic [RD_W-1:0]          rd_ch_i,
  output logic [SQ_W-1:0]          rd_sq_o,
  output logic [CMP_W-1:0]         rd_gt_o,
  output logic [CMP_W-1:0]         rd_lt_o,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, CAPTURE} state_t;

  state_t             state;
  logic [TIMER_W-1:0] period_q;
  logic [TIMER_W-1:0] cnt;
  logic [3:0]         settle_cnt;
  logic               load_bank;

  logic [SQ_W-1:0]    bank_sq [NCHAN];
  logic [CMP_W-1:0]   bank_gt [NCHAN];
  logic [CMP_W-1:0]   bank_lt [NCHAN];

  assign busy_o    = (state != IDLE);
  assign state_dbg = state;
  assign load_bank = (state == CAPTURE) && !abort_i;

  // start_i is a one-cycle request honoured only in IDLE (there is no ready);
  // busy_o going high the next cycle is the acceptance indication.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      period_q   <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      agc_tick_o <= 1'b0;
      agc_ce_o   <= 1'b0;
      done_o     <= 1'b0;
      capture_o  <= 1'b0;
      aborted_o  <= 1'b0;
      cfg_err_o  <= 1'b0;
      seq_o      <= '0;
    end else begin
      agc_tick_o <= 1'b0;
      capture_o  <= 1'b0;
      aborted_o  <= 1'b0;
      cfg_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            if (period_i != '0) begin
              period_q   <= period_i;
              cnt        <= TIMER_W'(1);
              done_o     <= 1'b0;
              agc_tick_o <= 1'b1;
              agc_ce_o   <= 1'b1;
              state      <= RUN;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state     <= IDLE;
            agc_ce_o  <= 1'b0;
            aborted_o <= 1'b1;
          end else if (cnt == period_q) begin
            // Up-counter compared against the latched period never wraps.
            state      <= SETTLE;
            agc_ce_o   <= 1'b0;
            settle_cnt <= 4'(CAPTURE_DELAY);
          end else begin
            cnt <= cnt + TIMER_W'(1);
          end
        end
        SETTLE: begin
          if (abort_i) begin
            state     <= IDLE;
            aborted_o <= 1'b1;
          end else if (settle_cnt == 4'd1) begin
            state     <= CAPTURE;
            capture_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          if (abort_i) begin
            state     <= IDLE;
            aborted_o <= 1'b1;
          end else begin
            seq_o  <= seq_o + 8'd1;
            done_o <= 1'b1;
            if (auto_i && (period_i != '0)) begin
              period_q   <= period_i;
              cnt        <= TIMER_W'(1);
              agc_tick_o <= 1'b1;
              agc_ce_o   <= 1'b1;
              state      <= RUN;
            end else begin
              state     <= IDLE;
              cfg_err_o <= auto_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCHAN; k++) begin
        bank_sq[k] <= '0;
        bank_gt[k] <= '0;
        bank_lt[k] <= '0;
      end
    end else if (load_bank) begin
      for (int k = 0; k < NCHAN; k++) begin
        bank_sq[k] <= sq_accum_i[k*SQ_W +: SQ_W];
        bank_gt[k] <= gt_accum_i[k*CMP_W +: CMP_W];
        bank_lt[k] <= lt_accum_i[k*CMP_W +: CMP_W];
      end
    end
  end

  // Readback samples the bank before this edge's capture update lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_sq_o <= '0;
      rd_gt_o <= '0;
      rd_lt_o <= '0;
    end else if (int'(rd_ch_i) < NCHAN) begin
      rd_sq_o <= bank_sq[rd_ch_i];
      rd_gt_o <= bank_gt[rd_ch_i];
      rd_lt_o <= bank_lt[rd_ch_i];
    end else begin
      rd_sq_o <= '0;
      rd_gt_o <= '0;
      rd_lt_o <= '0;
    end
  end

endmodule

// File: tb/tb_agc_multi_seq.sv
// Directed-vector bench for agc_multi_seq: a 4-channel instance for the main
// scenarios and a 3-channel instance for out-of-range readback.
module tb_agc_multi_seq;
  localparam int NCH   = 4;
  localparam int SQ_W  = 25;
  localparam int CMP_W = 21;
  localparam int TW    = 10;

  logic clk = 1'b0;
  logic rst, start, abort, auto_mode;
  logic [TW-1:0]         period;
  logic [NCH*SQ_W-1:0]   sq_accum;
  logic [NCH*CMP_W-1:0]  gt_accum, lt_accum;
  logic [1:0]            rd_ch, rd_ch_s;

  logic tick, ce, busy, done, capture, aborted, cfg_err;
  logic [7:0] seq;
  logic [SQ_W-1:0]  rd_sq;
  logic [CMP_W-1:0] rd_gt, rd_lt;
  logic [1:0] state_dbg;

  logic s_tick, s_ce, s_busy, s_done, s_capture, s_aborted, s_cfg_err;
  logic [7:0] s_seq;
  logic [SQ_W-1:0]  s_rd_sq;
  logic [CMP_W-1:0] s_rd_gt, s_rd_lt;
  logic [1:0] s_state_dbg;

  int errors = 0;
  int checks = 0;
  int exp_seq = 0;

  agc_multi_seq #(.NCHAN(NCH), .SQ_W(SQ_W), .CMP_W(CMP_W), .TIMER_W(TW), .CAPTURE_DELAY(6)) u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .auto_i(auto_mode),
    .period_i(period), .sq_accum_i(sq_accum), .gt_accum_i(gt_accum), .lt_accum_i(lt_accum),
    .agc_tick_o(tick), .agc_ce_o(ce), .busy_o(busy), .done_o(done), .capture_o(capture),
    .aborted_o(aborted), .cfg_err_o(cfg_err), .seq_o(seq), .rd_ch_i(rd_ch),
    .rd_sq_o(rd_sq), .rd_gt_o(rd_gt), .rd_lt_o(rd_lt), .state_dbg(state_dbg)
  );

  agc_multi_seq #(.NCHAN(3), .SQ_W(SQ_W), .CMP_W(CMP_W), .TIMER_W(TW), .CAPTURE_DELAY(6)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .auto_i(auto_mode),
    .period_i(period), .sq_accum_i(sq_accum[3*SQ_W-1:0]), .gt_accum_i(gt_accum[3*CMP_W-1:0]),
    .lt_accum_i(lt_accum[3*CMP_W-1:0]),
    .agc_tick_o(s_tick), .agc_ce_o(s_ce), .busy_o(s_busy), .done_o(s_done), .capture_o(s_capture),
    .aborted_o(s_aborted), .cfg_err_o(s_cfg_err), .seq_o(s_seq), .rd_ch_i(rd_ch_s),
    .rd_sq_o(s_rd_sq), .rd_gt_o(s_rd_gt), .rd_lt_o(s_rd_lt), .state_dbg(s_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; auto_mode = 1'b0; period = '0;
    sq_accum = '0; gt_accum = '0; lt_accum = '0; rd_ch = 2'd0; rd_ch_s = 2'd0;
    step(); step();
    rst = 1'b0;
    checks++; if ({tick, ce, busy, done, capture, aborted, cfg_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000000", {tick, ce, busy, done, capture, aborted, cfg_err}); end
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL reset_seq got=%0d exp=0", seq); end
    checks++; if ({rd_sq, rd_gt, rd_lt} !== '0) begin
      errors++; $display("FAIL reset_rd got=%h/%h/%h exp=0", rd_sq, rd_gt, rd_lt); end
    exp_seq = 0;
  endtask

  task automatic test_basic();
    logic [SQ_W-1:0]  e_sq;
    logic [CMP_W-1:0] e_gt, e_lt;
    int e_s;
    e_sq = 25'h1ABCDEF; e_gt = 21'h12345; e_lt = 21'h0F0F0;
    sq_accum[2*SQ_W +: SQ_W] = e_sq;
    gt_accum[2*CMP_W +: CMP_W] = e_gt;
    lt_accum[2*CMP_W +: CMP_W] = e_lt;
    period = 10'd4; auto_mode = 1'b0; rd_ch = 2'd2; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step(); start = 1'b0;
      e_s = (c >= 12) ? (exp_seq + 1) % 256 : exp_seq;
      checks++; if (tick !== (c == 1)) begin errors++; $display("FAIL basic_tick c=%0d got=%b", c, tick); end
      checks++; if (ce !== (c <= 4)) begin errors++; $display("FAIL basic_ce c=%0d got=%b", c, ce); end
      checks++; if (capture !== (c == 11)) begin errors++; $display("FAIL basic_capture c=%0d got=%b", c, capture); end
      checks++; if (done !== (c >= 12)) begin errors++; $display("FAIL basic_done c=%0d got=%b", c, done); end
      checks++; if (busy !== (c <= 11)) begin errors++; $display("FAIL basic_busy c=%0d got=%b", c, busy); end
      checks++; if (seq !== 8'(e_s)) begin errors++; $display("FAIL basic_seq c=%0d got=%0d exp=%0d", c, seq, e_s); end
      if (c == 12) begin
        checks++; if (rd_sq !== '0) begin errors++; $display("FAIL basic_rd_precapture got=%h exp=0", rd_sq); end
      end
      if (c == 13) begin
        checks++; if (rd_sq !== e_sq) begin errors++; $display("FAIL basic_rd_sq got=%h exp=%h", rd_sq, e_sq); end
        checks++; if (rd_gt !== e_gt) begin errors++; $display("FAIL basic_rd_gt got=%h exp=%h", rd_gt, e_gt); end
        checks++; if (rd_lt !== e_lt) begin errors++; $display("FAIL basic_rd_lt got=%h exp=%h", rd_lt, e_lt); end
      end
    end
    exp_seq = (exp_seq + 1) % 256;
  endtask

  task automatic test_zero_period();
    period = '0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(); start = 1'b0;
      checks++; if (cfg_err !== (c == 1)) begin errors++; $display("FAIL zero_cfg_err c=%0d got=%b", c, cfg_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy c=%0d got=%b exp=0", c, busy); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done c=%0d got=%b exp=1", c, done); end
    end
  endtask

  task automatic test_idle_abort();
    period = 10'd5; start = 1'b1; abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step(); start = 1'b0; abort = 1'b0;
      checks++; if ({busy, tick, aborted, cfg_err} !== 4'b0) begin
        errors++; $display("FAIL idle_abort c=%0d got=%b exp=0000", c, {busy, tick, aborted, cfg_err}); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL idle_abort_done c=%0d got=%b exp=1", c, done); end
    end
  endtask

  task automatic test_auto();
    int e_s;
    logic e_ce;
    period = 10'd3; auto_mode = 1'b1; start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step(); start = 1'b0;
      if (c == 30) auto_mode = 1'b0;
      e_s = (exp_seq + (c >= 11) + (c >= 21) + (c >= 31)) % 256;
      e_ce = (c <= 3) || (c >= 11 && c <= 13) || (c >= 21 && c <= 23);
      checks++; if (capture !== (c == 10 || c == 20 || c == 30)) begin errors++; $display("FAIL auto_capture c=%0d got=%b", c, capture); end
      checks++; if (tick !== (c == 1 || c == 11 || c == 21)) begin errors++; $display("FAIL auto_tick c=%0d got=%b", c, tick); end
      checks++; if (ce !== e_ce) begin errors++; $display("FAIL auto_ce c=%0d got=%b exp=%b", c, ce, e_ce); end
      checks++; if (done !== (c >= 11)) begin errors++; $display("FAIL auto_done c=%0d got=%b", c, done); end
      checks++; if (busy !== (c <= 30)) begin errors++; $display("FAIL auto_busy c=%0d got=%b", c, busy); end
      checks++; if (seq !== 8'(e_s)) begin errors++; $display("FAIL auto_seq c=%0d got=%0d exp=%0d", c, seq, e_s); end
    end
    exp_seq = (exp_seq + 3) % 256;
  endtask

  task automatic test_abort();
    sq_accum[2*SQ_W +: SQ_W] = 25'h0123456;
    gt_accum[2*CMP_W +: CMP_W] = 21'h0ABCD;
    lt_accum[2*CMP_W +: CMP_W] = 21'h1F00F;
    period = 10'd8; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = (c == 2);
      abort = (c == 3);
      checks++; if (tick !== (c == 1)) begin errors++; $display("FAIL abort_tick c=%0d got=%b", c, tick); end
      checks++; if (ce !== (c <= 3)) begin errors++; $display("FAIL abort_ce c=%0d got=%b", c, ce); end
      checks++; if (aborted !== (c == 4)) begin errors++; $display("FAIL abort_pulse c=%0d got=%b", c, aborted); end
      checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL abort_busy c=%0d got=%b", c, busy); end
      checks++; if ({capture, done} !== 2'b00) begin errors++; $display("FAIL abort_cap_done c=%0d got=%b exp=00", c, {capture, done}); end
      checks++; if (seq !== 8'(exp_seq)) begin errors++; $display("FAIL abort_seq c=%0d got=%0d exp=%0d", c, seq, exp_seq); end
    end
    checks++; if ({rd_sq, rd_gt, rd_lt} !== {25'h1ABCDEF, 21'h12345, 21'h0F0F0}) begin
      errors++; $display("FAIL abort_bank got=%h/%h/%h exp=1abcdef/12345/0f0f0", rd_sq, rd_gt, rd_lt); end
  endtask

  task automatic test_wrap();
    int ncap;
    bit hit;
    ncap = 0; hit = 1'b0;
    period = 10'd1; auto_mode = 1'b1; start = 1'b1;
    for (int c = 1; c <= 2600; c++) begin
      step(); start = 1'b0;
      if (capture === 1'b1) begin
        ncap++;
        if (ncap == 300) begin
          period = '0;
          hit = 1'b1;
          break;
        end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL wrap_timeout captures=%0d exp=300", ncap); end
    step();
    exp_seq = (exp_seq + 300) % 256;
    checks++; if (seq !== 8'(exp_seq)) begin errors++; $display("FAIL wrap_seq got=%0d exp=%0d", seq, exp_seq); end
    checks++; if ({cfg_err, busy, done} !== 3'b101) begin
      errors++; $display("FAIL wrap_rearm_zero got=%b exp=101", {cfg_err, busy, done}); end
    auto_mode = 1'b0;
    step();
    checks++; if ({cfg_err, busy} !== 2'b00) begin errors++; $display("FAIL wrap_after got=%b exp=00", {cfg_err, busy}); end
  endtask

  task automatic test_reset_midrun();
    period = 10'd16; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step(); start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_seq = 0;
    checks++; if ({tick, ce, busy, done, capture, aborted, cfg_err} !== 7'b0) begin
      errors++; $display("FAIL midreset_ctrl got=%b exp=0000000", {tick, ce, busy, done, capture, aborted, cfg_err}); end
    checks++; if (seq !== 8'd0) begin errors++; $display("FAIL midreset_seq got=%0d exp=0", seq); end
    checks++; if ({rd_sq, rd_gt, rd_lt} !== '0) begin errors++; $display("FAIL midreset_rd got=%h/%h/%h exp=0", rd_sq, rd_gt, rd_lt); end
    step();
    checks++; if ({aborted, busy, ce} !== 3'b0) begin errors++; $display("FAIL midreset_after got=%b exp=000", {aborted, busy, ce}); end
    checks++; if ({rd_sq, rd_gt, rd_lt} !== '0) begin errors++; $display("FAIL midreset_bank got=%h/%h/%h exp=0", rd_sq, rd_gt, rd_lt); end
  endtask

  task automatic test_boundary();
    sq_accum[2*SQ_W +: SQ_W] = 25'h0555555;
    gt_accum[2*CMP_W +: CMP_W] = 21'h0AAAA;
    lt_accum[2*CMP_W +: CMP_W] = 21'h15555;
    period = 10'd2; auto_mode = 1'b0; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step(); start = 1'b0;
      abort = (c == 9);
      if (c == 9) begin
        checks++; if (capture !== 1'b1) begin errors++; $display("FAIL bnd_capture got=%b exp=1", capture); end
      end
      if (c == 10) begin
        checks++; if ({aborted, busy, capture} !== 3'b100) begin errors++; $display("FAIL bnd_abort got=%b exp=100", {aborted, busy, capture}); end
      end
      if (c == 11) begin
        checks++; if (seq !== 8'(exp_seq)) begin errors++; $display("FAIL bnd_seq got=%0d exp=%0d", seq, exp_seq); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL bnd_done got=%b exp=0", done); end
        checks++; if ({rd_sq, rd_gt, rd_lt} !== {25'h1ABCDEF, 21'h12345, 21'h0F0F0}) begin
          errors++; $display("FAIL bnd_bank got=%h/%h/%h exp=1abcdef/12345/0f0f0", rd_sq, rd_gt, rd_lt); end
      end
    end
    rd_ch_s = 2'd2;
    step();
    checks++; if ({s_rd_sq, s_rd_gt, s_rd_lt} !== {25'h1ABCDEF, 21'h12345, 21'h0F0F0}) begin
      errors++; $display("FAIL bnd_small_ch2 got=%h/%h/%h exp=1abcdef/12345/0f0f0", s_rd_sq, s_rd_gt, s_rd_lt); end
    rd_ch_s = 2'd3;
    step();
    checks++; if ({s_rd_sq, s_rd_gt, s_rd_lt} !== '0) begin
      errors++; $display("FAIL bnd_out_of_range got=%h/%h/%h exp=0", s_rd_sq, s_rd_gt, s_rd_lt); end
  endtask

  task automatic test_max_period();
    int nce, ncap, cap_at;
    nce = 0; ncap = 0; cap_at = -1;
    period = '1; auto_mode = 1'b0; start = 1'b1;
    for (int c = 1; c <= 1040; c++) begin
      step(); start = 1'b0;
      if (ce === 1'b1) nce++;
      if (capture === 1'b1) begin ncap++; cap_at = c; end
    end
    exp_seq = (exp_seq + 1) % 256;
    checks++; if (nce != 1023) begin errors++; $display("FAIL max_ce_count got=%0d exp=1023", nce); end
    checks++; if (ncap != 1) begin errors++; $display("FAIL max_captures got=%0d exp=1", ncap); end
    checks++; if (cap_at != 1030) begin errors++; $display("FAIL max_capture_cycle got=%0d exp=1030", cap_at); end
    checks++; if (seq !== 8'(exp_seq)) begin errors++; $display("FAIL max_seq got=%0d exp=%0d", seq, exp_seq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_period();
    test_idle_abort();
    test_auto();
    test_abort();
    test_wrap();
    test_reset_midrun();
    test_basic();
    test_boundary();
    test_max_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
